fft_frame_packer: RTL and testbench

- Upstream feeder for the streaming FFT/IFFT core (dft_top / idft_top), which takes a one-cycle `next` pulse and then 16 x 32-bit words per cycle (8 complex lanes, re/im interleaved).
- Accepts a serial stream of complex samples on a valid/ready handshake and packs them into full transform frames in a ping-pong buffer.
- Replays each frame as `next` followed by BEATS consecutive wide beats, with a guaranteed minimum gap between frames.

---
 rtl/fft_frame_packer.sv | 165 ++++++++++++++++
 tb/tb_fft_frame_packer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_packer.sv
// rtl/fft_frame_packer.sv - ping-pong packer turning a serial complex stream into FFT frames
// Build option FFT_PACK_ZEROPAD_EN: an early s_last closes the frame and unfilled lanes read as zero.
module fft_frame_packer #(
   parameter int DATA_W  = 32,
   parameter int LANES   = 8,
   parameter int BEATS   = 1,
   parameter int GAP_MIN = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [DATA_W-1:0]           s_re,
   input  logic [DATA_W-1:0]           s_im,
   input  logic                        s_last,
   output logic                        next,
   output logic [2*LANES*DATA_W-1:0]   out_data,
   output logic                        frame_err,
   output logic                        busy
);

   localparam int F  = LANES * BEATS;
   localparam int CW = (F > 1) ? $clog2(F) : 1;
   localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int GW = (GAP_MIN > 1) ? $clog2(GAP_MIN) : 1;

   typedef enum logic [1:0] {IDLE, NEXT, STREAM, GAP} state_t;

   state_t                     state;
   logic [1:0]                 full;
   logic                       wr_bank;
   logic                       rd_bank;
   logic                       run;
   logic [CW-1:0]              wr_cnt;
   logic [BW-1:0]              beat_cnt;
   logic [GW-1:0]              gap_cnt;
   logic [DATA_W-1:0]          mem_re [2][F];
   logic [DATA_W-1:0]          mem_im [2][F];
   logic                       accept;
   logic                       at_end;
   logic                       close_frame;
   logic                       last_beat;
   logic [2*LANES*DATA_W-1:0]  ld_data;
`ifdef FFT_PACK_ZEROPAD_EN
   logic [CW:0]                vcnt [2];
`endif

   // run holds s_ready low until the first edge after reset is released
   assign s_ready   = run && !full[wr_bank];
   assign accept    = s_valid && s_ready;
   assign at_end    = (wr_cnt == CW'(F - 1));
   assign last_beat = (beat_cnt == BW'(BEATS - 1));
   assign busy      = (|full) || (state != IDLE);
`ifdef FFT_PACK_ZEROPAD_EN
   assign close_frame = accept && (at_end || s_last);
`else
   assign close_frame = accept && at_end;
`endif

   always_ff @(posedge clk) begin
      if (accept) begin
         mem_re[wr_bank][wr_cnt] <= s_re;
         mem_im[wr_bank][wr_cnt] <= s_im;
      end
   end

   // beat to be presented next: beat 0 when leaving NEXT, otherwise the following beat
   always_comb begin
      int            b;
      logic [CW-1:0] idx;
      ld_data = '0;
      idx     = '0;
      b       = (state == NEXT) ? 0 : int'(beat_cnt) + 1;
      for (int k = 0; k < LANES; k++) begin
         idx = CW'(b * LANES + k);
`ifdef FFT_PACK_ZEROPAD_EN
         if ({1'b0, idx} < vcnt[rd_bank]) begin
            ld_data[(2*k)*DATA_W +: DATA_W]   = mem_re[rd_bank][idx];
            ld_data[(2*k+1)*DATA_W +: DATA_W] = mem_im[rd_bank][idx];
         end
`else
         ld_data[(2*k)*DATA_W +: DATA_W]   = mem_re[rd_bank][idx];
         ld_data[(2*k+1)*DATA_W +: DATA_W] = mem_im[rd_bank][idx];
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run       <= 1'b0;
         state     <= IDLE;
         full      <= 2'b00;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         wr_cnt    <= '0;
         beat_cnt  <= '0;
         gap_cnt   <= '0;
         next      <= 1'b0;
         out_data  <= '0;
         frame_err <= 1'b0;
`ifdef FFT_PACK_ZEROPAD_EN
         vcnt[0]   <= '0;
         vcnt[1]   <= '0;
`endif
      end else begin
         run       <= 1'b1;
         next      <= 1'b0;
         frame_err <= 1'b0;

         if (accept) begin
            if ((at_end && !s_last) || (s_last && !at_end))
               frame_err <= 1'b1;
            if (close_frame) begin
               full[wr_bank] <= 1'b1;
               wr_bank       <= ~wr_bank;
               wr_cnt        <= '0;
`ifdef FFT_PACK_ZEROPAD_EN
               vcnt[wr_bank] <= {1'b0, wr_cnt} + 1'b1;
`endif
            end else begin
               wr_cnt <= wr_cnt + 1'b1;
            end
         end

         // a full write bank blocks accept, so the bank being freed here is never being set
         case (state)
            IDLE: begin
               if (full[rd_bank]) begin
                  state <= NEXT;
                  next  <= 1'b1;
               end
            end
            NEXT: begin
               state    <= STREAM;
               beat_cnt <= '0;
               out_data <= ld_data;
            end
            STREAM: begin
               if (last_beat) begin
                  full[rd_bank] <= 1'b0;
                  rd_bank       <= ~rd_bank;
                  out_data      <= '0;
                  if (GAP_MIN > 0) begin
                     state   <= GAP;
                     gap_cnt <= GW'(GAP_MIN - 1);
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  beat_cnt <= beat_cnt + 1'b1;
                  out_data <= ld_data;
               end
            end
            GAP: begin
               if (gap_cnt == '0)
                  state <= IDLE;
               else
                  gap_cnt <= gap_cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_frame_packer.sv
// tb/tb_fft_frame_packer.sv - directed self-checking bench for fft_frame_packer
module tb_fft_frame_packer;
   localparam int DW = 32;
   localparam int L  = 8;
   localparam int WW = 2 * L * DW;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int failures = 0;
   int stalls = 0;

   logic          a_valid = 1'b0, a_last = 1'b0;
   logic [DW-1:0] a_re = '0, a_im = '0;
   logic          a_ready, a_next, a_err, a_busy;
   logic [WW-1:0] a_data;
   logic          g_valid = 1'b0, g_last = 1'b0;
   logic [DW-1:0] g_re = '0, g_im = '0;
   logic          g_ready, g_next, g_err, g_busy;
   logic [WW-1:0] g_data;
   logic          b_valid = 1'b0, b_last = 1'b0;
   logic [DW-1:0] b_re = '0, b_im = '0;
   logic          b_ready, b_next, b_err, b_busy;
   logic [WW-1:0] b_data;

   fft_frame_packer #(.DATA_W(DW), .LANES(L), .BEATS(1), .GAP_MIN(0)) u_a (
      .clk(clk), .reset(reset), .s_valid(a_valid), .s_ready(a_ready), .s_re(a_re), .s_im(a_im),
      .s_last(a_last), .next(a_next), .out_data(a_data), .frame_err(a_err), .busy(a_busy));
   fft_frame_packer #(.DATA_W(DW), .LANES(L), .BEATS(1), .GAP_MIN(20)) u_g (
      .clk(clk), .reset(reset), .s_valid(g_valid), .s_ready(g_ready), .s_re(g_re), .s_im(g_im),
      .s_last(g_last), .next(g_next), .out_data(g_data), .frame_err(g_err), .busy(g_busy));
   fft_frame_packer #(.DATA_W(DW), .LANES(L), .BEATS(2), .GAP_MIN(0)) u_b (
      .clk(clk), .reset(reset), .s_valid(b_valid), .s_ready(b_ready), .s_re(b_re), .s_im(b_im),
      .s_last(b_last), .next(b_next), .out_data(b_data), .frame_err(b_err), .busy(b_busy));

   int            a_nt[$], g_nt[$];
   logic [WW-1:0] a_bq[$], g_bq[$];
   int            a_errs = 0, g_errs = 0;
   bit            a_nd = 1'b0, g_nd = 1'b0;

   always @(negedge clk) begin
      if (a_nd) a_bq.push_back(a_data);
      if (a_next) a_nt.push_back(cyc);
      if (a_err) a_errs++;
      a_nd = a_next;
      if (g_nd) g_bq.push_back(g_data);
      if (g_next) g_nt.push_back(cyc);
      if (g_err) g_errs++;
      g_nd = g_next;
   end

   function automatic logic [WW-1:0] mk(input int r, input int i, input int n);
      logic [WW-1:0] v;
      v = '0;
      for (int k = 0; k < n; k++) begin
         v[(2*k)*DW +: DW]   = DW'(r + k);
         v[(2*k+1)*DW +: DW] = DW'(i + k);
      end
      return v;
   endfunction

   function automatic bit rdy(input int sel);
      case (sel)
         0: return a_ready;
         1: return g_ready;
         default: return b_ready;
      endcase
   endfunction

   task automatic send(input int sel, input logic [DW-1:0] re, input logic [DW-1:0] im, input logic last);
      int n;
      n = 0;
      case (sel)
         0: begin a_valid = 1'b1; a_re = re; a_im = im; a_last = last; end
         1: begin g_valid = 1'b1; g_re = re; g_im = im; g_last = last; end
         default: begin b_valid = 1'b1; b_re = re; b_im = im; b_last = last; end
      endcase
      while (!rdy(sel) && n < 200) begin
         @(negedge clk);
         n++;
      end
      stalls += n;
      if (n >= 200) begin
         checks++;
         failures++;
         $display("FAIL send_timeout sel=%0d: s_ready low for %0d cycles, expected 1", sel, n);
      end
      @(negedge clk);
      a_valid = 1'b0; g_valid = 1'b0; b_valid = 1'b0;
      a_last = 1'b0; g_last = 1'b0; b_last = 1'b0;
   endtask

   task automatic send_frame(input int sel, input int r, input int i, input int n, input int last_at);
      for (int k = 0; k < n; k++) send(sel, DW'(r + k), DW'(i + k), k == last_at);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic clear_a;
      a_nt.delete(); a_bq.delete(); a_errs = 0;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b expected 0", a_ready); end
      checks++; if (a_next !== 1'b0) begin failures++; $display("FAIL rst_next: got %b expected 0", a_next); end
      checks++; if (a_data !== '0) begin failures++; $display("FAIL rst_data: got %h expected 0", a_data); end
      checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b expected 0", a_err); end
      checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", a_busy); end
      reset = 1'b1;
      #1;
      checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_release: got %b expected 0", a_ready); end
      @(negedge clk);
      checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_rise: got %b expected 1", a_ready); end
   endtask

   task automatic test_single;
      clear_a();
      send_frame(0, 0, 'h100, 8, 7);
      @(negedge clk);
      checks++; if (a_next !== 1'b1) begin failures++; $display("FAIL single_next: got %b expected 1", a_next); end
      checks++; if (a_data !== '0) begin failures++; $display("FAIL single_data_pre: got %h expected 0", a_data); end
      @(negedge clk);
      checks++; if (a_next !== 1'b0) begin failures++; $display("FAIL single_next_drop: got %b expected 0", a_next); end
      checks++; if (a_data !== mk(0, 'h100, 8)) begin failures++; $display("FAIL single_beat: got %h expected %h", a_data, mk(0, 'h100, 8)); end
      @(negedge clk);
      checks++; if (a_data !== '0) begin failures++; $display("FAIL single_data_post: got %h expected 0", a_data); end
      idle(2);
      checks++; if (a_errs !== 0) begin failures++; $display("FAIL single_err: got %0d pulses expected 0", a_errs); end
   endtask

   task automatic test_missing_last;
      clear_a();
      send_frame(0, 'h40, 'h50, 8, -1);
      idle(5);
      checks++; if (a_errs !== 1) begin failures++; $display("FAIL nolast_err: got %0d pulses expected 1", a_errs); end
      checks++; if (a_nt.size() !== 1) begin failures++; $display("FAIL nolast_next: got %0d pulses expected 1", a_nt.size()); end
      if (a_bq.size() > 0) begin
         checks++; if (a_bq[0] !== mk('h40, 'h50, 8)) begin failures++; $display("FAIL nolast_data: got %h expected %h", a_bq[0], mk('h40, 'h50, 8)); end
      end
   endtask

   task automatic test_back_to_back;
      clear_a();
      stalls = 0;
      for (int j = 0; j < 3; j++) send_frame(0, 'h1000 + 8*j, 'h2000 + 8*j, 8, 7);
      idle(8);
      checks++; if (stalls !== 0) begin failures++; $display("FAIL b2b_ready: got %0d stall cycles expected 0", stalls); end
      checks++; if (a_nt.size() !== 3) begin failures++; $display("FAIL b2b_next_count: got %0d expected 3", a_nt.size()); end
      if (a_nt.size() == 3 && a_bq.size() == 3) begin
         for (int j = 1; j < 3; j++) begin
            checks++; if (a_nt[j] - a_nt[j-1] !== 8) begin failures++; $display("FAIL b2b_spacing%0d: got %0d expected 8", j, a_nt[j] - a_nt[j-1]); end
         end
         for (int j = 0; j < 3; j++) begin
            checks++; if (a_bq[j] !== mk('h1000 + 8*j, 'h2000 + 8*j, 8)) begin failures++; $display("FAIL b2b_data%0d: got %h expected %h", j, a_bq[j], mk('h1000 + 8*j, 'h2000 + 8*j, 8)); end
         end
      end
      checks++; if (a_errs !== 0) begin failures++; $display("FAIL b2b_err: got %0d expected 0", a_errs); end
   endtask

   task automatic test_early_last;
      clear_a();
      send_frame(0, 'h300, 'h400, 5, 4);
      idle(4);
      checks++; if (a_errs !== 1) begin failures++; $display("FAIL early_err: got %0d pulses expected 1", a_errs); end
`ifdef FFT_PACK_ZEROPAD_EN
      checks++; if (a_nt.size() !== 1) begin failures++; $display("FAIL early_next: got %0d expected 1", a_nt.size()); end
      if (a_bq.size() > 0) begin
         checks++; if (a_bq[0] !== mk('h300, 'h400, 5)) begin failures++; $display("FAIL early_pad: got %h expected %h", a_bq[0], mk('h300, 'h400, 5)); end
      end
`else
      checks++; if (a_nt.size() !== 0) begin failures++; $display("FAIL early_hold: got %0d next pulses expected 0", a_nt.size()); end
      send_frame(0, 'h305, 'h405, 3, 2);
      idle(4);
      checks++; if (a_nt.size() !== 1) begin failures++; $display("FAIL early_next: got %0d expected 1", a_nt.size()); end
      if (a_bq.size() > 0) begin
         checks++; if (a_bq[0] !== mk('h300, 'h400, 8)) begin failures++; $display("FAIL early_data: got %h expected %h", a_bq[0], mk('h300, 'h400, 8)); end
      end
      checks++; if (a_errs !== 1) begin failures++; $display("FAIL early_err_total: got %0d expected 1", a_errs); end
`endif
   endtask

   task automatic test_reset_mid;
      send_frame(0, 'h500, 'h600, 4, -1);
      reset = 1'b0;
      #1;
      checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready: got %b expected 0", a_ready); end
      checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", a_busy); end
      @(negedge clk);
      checks++; if (a_data !== '0 || a_next !== 1'b0 || a_err !== 1'b0) begin failures++; $display("FAIL midrst_outs: got data=%h next=%b err=%b expected all 0", a_data, a_next, a_err); end
      reset = 1'b1;
      @(negedge clk);
      clear_a();
      send_frame(0, 'h700, 'h800, 8, 7);
      idle(5);
      checks++; if (a_nt.size() !== 1) begin failures++; $display("FAIL midrst_next: got %0d expected 1", a_nt.size()); end
      if (a_bq.size() > 0) begin
         checks++; if (a_bq[0] !== mk('h700, 'h800, 8)) begin failures++; $display("FAIL midrst_data: got %h expected %h", a_bq[0], mk('h700, 'h800, 8)); end
      end
      checks++; if (a_errs !== 0) begin failures++; $display("FAIL midrst_err: got %0d expected 0", a_errs); end
   endtask

   task automatic test_gap;
      int n;
      g_nt.delete(); g_bq.delete(); g_errs = 0;
      for (int j = 0; j < 3; j++) send_frame(1, 'hA000 + 8*j, 'hB000 + 8*j, 8, 7);
      #1;
      checks++; if (g_ready !== 1'b0) begin failures++; $display("FAIL gap_ready_full: got %b expected 0", g_ready); end
      checks++; if (g_busy !== 1'b1) begin failures++; $display("FAIL gap_busy: got %b expected 1", g_busy); end
      n = 0;
      while (g_nt.size() < 3 && n < 300) begin
         @(negedge clk);
         n++;
      end
      idle(25);
      checks++; if (g_nt.size() !== 3) begin failures++; $display("FAIL gap_next_count: got %0d expected 3", g_nt.size()); end
      if (g_nt.size() == 3 && g_bq.size() == 3) begin
         for (int j = 1; j < 3; j++) begin
            checks++; if (g_nt[j] - g_nt[j-1] < 22) begin failures++; $display("FAIL gap_spacing%0d: got %0d expected >=22", j, g_nt[j] - g_nt[j-1]); end
         end
         for (int j = 0; j < 3; j++) begin
            checks++; if (g_bq[j] !== mk('hA000 + 8*j, 'hB000 + 8*j, 8)) begin failures++; $display("FAIL gap_data%0d: got %h expected %h", j, g_bq[j], mk('hA000 + 8*j, 'hB000 + 8*j, 8)); end
         end
      end
      checks++; if (g_ready !== 1'b1 || g_busy !== 1'b0) begin failures++; $display("FAIL gap_drained: got ready=%b busy=%b expected 1 0", g_ready, g_busy); end
      checks++; if (g_errs !== 0) begin failures++; $display("FAIL gap_err: got %0d expected 0", g_errs); end
   endtask

   task automatic test_beats2;
      send_frame(2, 'hC00, 'hD00, 16, 15);
      @(negedge clk);
      checks++; if (b_next !== 1'b1) begin failures++; $display("FAIL b2_next: got %b expected 1", b_next); end
      @(negedge clk);
      checks++; if (b_data !== mk('hC00, 'hD00, 8)) begin failures++; $display("FAIL b2_beat0: got %h expected %h", b_data, mk('hC00, 'hD00, 8)); end
      @(negedge clk);
      checks++; if (b_data !== mk('hC08, 'hD08, 8)) begin failures++; $display("FAIL b2_beat1: got %h expected %h", b_data, mk('hC08, 'hD08, 8)); end
      @(negedge clk);
      checks++; if (b_data !== '0) begin failures++; $display("FAIL b2_after: got %h expected 0", b_data); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_missing_last();
      test_back_to_back();
      test_early_last();
      test_reset_mid();
      test_gap();
      test_beats2();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
